// File: rtl/imm_pkg.sv
// Shared types and helpers for the RISC-V immediate encoder: format select,
// per-format immediate field masks, field scattering and range checking.
package imm_pkg;

    localparam int IMM_W = 32;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_U   = 3'b011,
        IMM_J   = 3'b100,
        IMM_UNS = 3'b101
    } imm_src_t;

    // Indexed by the 3-bit select; codes 110/111 reuse the I-format mask.
    localparam logic [7:0][IMM_W-1:0] MASK = {
        32'hFFF0_0000,  // 111 -> I
        32'hFFF0_0000,  // 110 -> I
        32'hFFF0_0000,  // UNS
        32'hFFFF_F000,  // J
        32'hFFFF_F000,  // U
        32'hFE00_0F80,  // B
        32'hFE00_0F80,  // S
        32'hFFF0_0000   // I
    };

    function automatic imm_src_t decodeSrc(input logic [2:0] raw);
        imm_src_t fmt;
        case (raw)
            3'b001:  fmt = IMM_S;
            3'b010:  fmt = IMM_B;
            3'b011:  fmt = IMM_U;
            3'b100:  fmt = IMM_J;
            3'b101:  fmt = IMM_UNS;
            default: fmt = IMM_I;
        endcase
        return fmt;
    endfunction

    function automatic logic [IMM_W-1:0] immFields(input imm_src_t fmt,
                                                   input logic [IMM_W-1:0] imm);
        logic [IMM_W-1:0] fields;
        case (fmt)
            IMM_S:   fields = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            IMM_B:   fields = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            IMM_U:   fields = {imm[31:12], 12'b0};
            IMM_J:   fields = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            default: fields = {imm[11:0], 20'b0};
        endcase
        return fields;
    endfunction

    // A signed field is representable when every bit above its top bit
    // matches that top bit, i.e. the upper slice is all ones or all zeros.
    function automatic logic rangeErr(input imm_src_t fmt,
                                      input logic [IMM_W-1:0] imm);
        logic sext11;
        logic sext12;
        logic sext20;
        logic err;
        sext11 = (&imm[31:11]) | ~(|imm[31:11]);
        sext12 = (&imm[31:12]) | ~(|imm[31:12]);
        sext20 = (&imm[31:20]) | ~(|imm[31:20]);
        case (fmt)
            IMM_B:   err = imm[0] | ~sext12;
            IMM_U:   err = |imm[11:0];
            IMM_J:   err = imm[0] | ~sext20;
            IMM_UNS: err = |imm[31:12];
            default: err = ~sext11;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/imm_enc_fifo.sv
// Two-entry synchronous FIFO with valid/ready on both sides; the ready
// flag depends only on registered occupancy, never on the pop side.
module imm_enc_fifo #(
    parameter int            DW         = 65,
    parameter logic [DW-1:0] RESET_DATA = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pushValid_i,
    output logic          pushReady_o,
    input  logic [DW-1:0] pushData_i,
    output logic          popValid_o,
    input  logic          popReady_i,
    output logic [DW-1:0] popData_o
);

    logic [DW-1:0] mem_q [2];
    logic          wrPtr_q;
    logic          wrPtr_d;
    logic          rdPtr_q;
    logic          rdPtr_d;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          doPush;
    logic          doPop;

    // Gating with rst keeps both handshakes idle during the reset cycle.
    assign pushReady_o = !rst && (count_q != 2'd2);
    assign popValid_o  = !rst && (count_q != 2'd0);
    assign doPush      = pushValid_i && pushReady_o;
    assign doPop       = popValid_o && popReady_i;
    assign popData_o   = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q ^ doPush;
        rdPtr_d = rdPtr_q ^ doPop;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 2'd1;
        end else if (!doPush && doPop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= RESET_DATA;
            end
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: scatters an immediate into a blank instruction word,
// flags values the format cannot hold, and tags each word with its address.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int           W    = 32,
    parameter logic [W-1:0] BASE = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   IMMsrc,
    input  logic [W-1:0] base_instr,
    input  logic [W-1:0] imm,
    input  logic         restart,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_instr,
    output logic [W-1:0] out_addr,
    output logic         out_err,
    output logic         err_sticky
);

    localparam int DW = 2 * W + 1;

    imm_src_t      fmt;
    logic [W-1:0]  encInstr;
    logic          encErr;
    logic          accept;
    logic [W-1:0]  wordAddr;
    logic [W-1:0]  addrCnt_q;
    logic [W-1:0]  addrCnt_d;
    logic          errSticky_q;
    logic          errSticky_d;
    logic [DW-1:0] pushData;
    logic [DW-1:0] popData;

    assign fmt      = decodeSrc(IMMsrc);
    assign encInstr = (base_instr & ~MASK[fmt]) | immFields(fmt, imm);
    assign encErr   = rangeErr(fmt, imm);
    assign accept   = in_valid && in_ready;

    // A restart in the same cycle as an accept hands that word BASE itself.
    assign wordAddr = restart ? BASE : addrCnt_q;
    assign pushData = {encErr, wordAddr, encInstr};

    always_comb begin
        addrCnt_d   = addrCnt_q;
        errSticky_d = errSticky_q | (accept & encErr);
        if (accept) begin
            addrCnt_d = wordAddr + W'(4);
        end else if (restart) begin
            addrCnt_d = BASE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addrCnt_q   <= BASE;
            errSticky_q <= 1'b0;
        end else begin
            addrCnt_q   <= addrCnt_d;
            errSticky_q <= errSticky_d;
        end
    end

    imm_enc_fifo #(
        .DW         (DW),
        .RESET_DATA ({1'b0, BASE, {W{1'b0}}})
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .pushValid_i (in_valid),
        .pushReady_o (in_ready),
        .pushData_i  (pushData),
        .popValid_o  (out_valid),
        .popReady_i  (out_ready),
        .popData_o   (popData)
    );

    assign out_instr  = popData[W-1:0];
    assign out_addr   = popData[2*W-1:W];
    assign out_err    = popData[DW-1];
    assign err_sticky = errSticky_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors push expected words,
// a negedge monitor compares every word the DUT presents against the queue.
module tb_imm_encoder;

    localparam int          W    = 32;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  IMMsrc;
    logic [31:0] base_instr;
    logic [31:0] imm;
    logic        restart;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_sticky;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t        expQ[$];
    vec_t        vecs [0:13];
    logic [31:0] expAddr;
    int          checks;
    int          errors;
    int          cyc;

    imm_encoder #(
        .W    (W),
        .BASE (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .IMMsrc     (IMMsrc),
        .base_instr (base_instr),
        .imm        (imm),
        .restart    (restart),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: the front entry must be on the outputs whenever out_valid is
    // high; it is retired only when the consumer also accepts it.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %h@%h with nothing expected",
                             out_instr, out_addr);
                end else begin
                    checkOutput("out_instr", out_instr, expQ[0].instr);
                    checkOutput("out_addr", out_addr, expQ[0].addr);
                    checkOutput("out_err", {31'b0, out_err}, {31'b0, expQ[0].err});
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] src, input logic [31:0] baseW,
                                 input logic [31:0] immW, input logic [31:0] expInstr,
                                 input logic expErr, input logic doRestart,
                                 input int maxCycles, output logic accepted);
        exp_t e;
        IMMsrc     = src;
        base_instr = baseW;
        imm        = immW;
        in_valid   = 1'b1;
        restart    = doRestart;
        accepted   = 1'b0;
        for (int c = 0; c < maxCycles && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.instr  = expInstr;
                e.addr   = doRestart ? BASE : expAddr;
                e.err    = expErr;
                expQ.push_back(e);
                expAddr  = e.addr + 32'd4;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic sendVec(input vec_t v, input logic doRestart);
        logic acc;
        applyStimulus(v.src, v.base, v.imm, v.instr, v.err, doRestart, 20, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready %b expected 1", in_ready);
        end
    endtask

    task automatic doReset(input logic checkState);
        rst      = 1'b1;
        in_valid = 1'b0;
        restart  = 1'b0;
        expQ.delete();
        expAddr  = BASE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (checkState) begin
            checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("rst_out_instr", out_instr, 32'd0);
            checkOutput("rst_out_addr", out_addr, BASE);
            checkOutput("rst_out_err", {31'b0, out_err}, 32'd0);
        end
        checkOutput("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (checkState) begin
            @(negedge clk);
            checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
            checkOutput("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("post_rst_out_addr", out_addr, BASE);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drainQueue();
        out_ready = 1'b1;
        for (int c = 0; c < 50 && expQ.size() != 0; c++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d words pending expected 0", expQ.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        int   t0;

        // src, base, imm, expected instr, expected err
        vecs[0]  = '{3'b000, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
        vecs[1]  = '{3'b001, 32'h0011_2023, 32'h0000_07FC, 32'h7E11_2E23, 1'b0};
        vecs[2]  = '{3'b010, 32'h0020_8063, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
        vecs[3]  = '{3'b011, 32'h0000_02B7, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        vecs[4]  = '{3'b011, 32'h0000_02B7, 32'h1234_5001, 32'h1234_52B7, 1'b1};
        vecs[5]  = '{3'b100, 32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0};
        vecs[6]  = '{3'b100, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
        vecs[7]  = '{3'b101, 32'h0000_0013, 32'h0000_0FFF, 32'hFFF0_0013, 1'b0};
        vecs[8]  = '{3'b101, 32'h0000_0013, 32'h0000_1000, 32'h0000_0013, 1'b1};
        vecs[9]  = '{3'b000, 32'hABC0_0093, 32'h0000_0005, 32'h0050_0093, 1'b0};
        vecs[10] = '{3'b000, 32'h0000_0093, 32'h0000_0800, 32'h8000_0093, 1'b1};
        vecs[11] = '{3'b110, 32'h0000_0093, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
        vecs[12] = '{3'b001, 32'h0011_2023, 32'hFFFF_F7FF, 32'h7E11_2FA3, 1'b1};
        vecs[13] = '{3'b100, 32'h0000_006F, 32'h0000_0801, 32'h0010_006F, 1'b1};

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        restart    = 1'b0;
        out_ready  = 1'b0;
        IMMsrc     = 3'b000;
        base_instr = 32'd0;
        imm        = 32'd0;
        expAddr    = BASE;

        $display("[TB] reset state");
        doReset(1'b1);

        $display("[TB] directed vectors at full rate");
        out_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 14; i++) begin
            sendVec(vecs[i], 1'b0);
            if (i == 0) checkOutput("latency_out_valid", {31'b0, out_valid}, 32'd1);
        end
        checkOutput("throughput_cycles", cyc - t0, 32'd14);
        drainQueue();

        $display("[TB] sticky error");
        doReset(1'b0);
        sendVec(vecs[2], 1'b0);
        checkOutput("sticky_clean", {31'b0, err_sticky}, 32'd0);
        sendVec('{3'b010, 32'h0020_8063, 32'h0000_0003, 32'h0020_8163, 1'b1}, 1'b0);
        checkOutput("sticky_set", {31'b0, err_sticky}, 32'd1);
        sendVec(vecs[0], 1'b0);
        checkOutput("sticky_held", {31'b0, err_sticky}, 32'd1);
        drainQueue();
        doReset(1'b0);

        $display("[TB] backpressure with address wrap");
        out_ready = 1'b0;
        sendVec(vecs[0], 1'b0);
        sendVec(vecs[1], 1'b0);
        applyStimulus(vecs[3].src, vecs[3].base, vecs[3].imm, vecs[3].instr,
                      vecs[3].err, 1'b0, 3, acc);
        checkOutput("bp_third_blocked", {31'b0, acc}, 32'd0);
        checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        sendVec(vecs[3], 1'b0);
        drainQueue();

        $display("[TB] restart");
        sendVec(vecs[5], 1'b1);
        sendVec(vecs[6], 1'b0);
        sendVec(vecs[7], 1'b0);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        expAddr = BASE;
        sendVec(vecs[9], 1'b0);
        drainQueue();

        $display("[TB] reset with buffered words");
        out_ready = 1'b0;
        sendVec(vecs[0], 1'b0);
        sendVec(vecs[1], 1'b0);
        doReset(1'b1);
        out_ready = 1'b1;
        sendVec(vecs[2], 1'b0);
        drainQueue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
